// File: rtl/instr_encoder_if.sv
// Handshake and instruction-memory bus between the program loader and its client.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        op;
    logic              imm_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              err;
    logic              busy;
    logic              done;
    logic              full;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, in_last, op, imm_sel, rs, rt, rd, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, err, busy, done, full, count
    );

    modport slave (
        input  start, in_valid, in_last, op, imm_sel, rs, rt, rd, imm,
        output in_ready, mem_we, mem_addr, mem_wdata, err, busy, done, full, count
    );
endinterface

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder / program loader.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting fields and writing encoded words
// DONE  | session finished (last seen or memory full), waiting for start
//
// A transfer is registered straight onto the memory bus, so the write appears
// one cycle later. A transfer that ends the session (in_last, or the one that
// fills memory) sets a pending-end flag that drops in_ready immediately and
// moves the FSM to DONE once that write/err cycle has gone by.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    instr_encoder_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic              full_r;
    logic              ending;
    logic              we_r;
    logic              err_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              in_ready_c;
    logic              busy_c;
    logic              done_c;
    logic              xfer;
    logic              legal;
    logic [5:0]        funct;
    logic [31:0]       enc;

    // Field decode: legality check and 32-bit MIPS word packing.
    always_comb begin
        funct = 6'b000000;
        legal = 1'b0;
        case (bus.op)
            3'b000:  begin funct = 6'b100000; legal = 1'b1; end
            3'b100:  begin funct = 6'b100100; legal = 1'b1; end
            3'b010:  begin funct = 6'b100101; legal = 1'b1; end
            3'b011:  begin funct = 6'b100010; legal = 1'b1; end
            3'b111:  begin funct = 6'b101010; legal = 1'b1; end
            default: begin funct = 6'b000000; legal = 1'b0; end
        endcase
        if (bus.imm_sel) begin
            legal = (bus.op == 3'b000);
            enc   = {6'b001000, bus.rs, bus.rt, bus.imm};
        end else begin
            enc   = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, funct};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state and state-derived handshake/status outputs.
    always_comb begin
        state_nx   = state;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                busy_c     = 1'b1;
                in_ready_c = !full_r && !ending;
                if (ending) state_nx = S_DONE;
            end
            S_DONE: begin
                done_c = 1'b1;
                if (bus.start) state_nx = S_LOAD;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign xfer = bus.in_valid && in_ready_c;

    // Write pointer, count, full flag and the registered memory/err outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            cnt     <= '0;
            full_r  <= 1'b0;
            ending  <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else begin
            we_r  <= 1'b0;
            err_r <= 1'b0;
            if (state != S_LOAD && bus.start) begin
                ptr    <= '0;
                cnt    <= '0;
                full_r <= 1'b0;
                ending <= 1'b0;
            end else if (state == S_LOAD && ending) begin
                ending <= 1'b0;
            end
            if (xfer) begin
                if (legal) begin
                    we_r    <= 1'b1;
                    addr_r  <= ptr;
                    wdata_r <= enc;
                    cnt     <= cnt + 1'b1;
                    // The last slot leaves the pointer in place rather than wrapping.
                    if (cnt == CNT_LAST) begin
                        full_r <= 1'b1;
                        ending <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end else begin
                    err_r <= 1'b1;
                end
                if (bus.in_last) ending <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.full      = full_r;
    assign bus.count     = cnt;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder built with a 4-word memory so the full case is reachable.
module tb_instr_encoder;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: legality and encoding built arithmetically from the ISA field layout.
    function automatic bit m_legal(input logic [2:0] op, input logic imm_sel);
        if (imm_sel) return op == 3'd0;
        return (op == 3'd0) || (op == 3'd4) || (op == 3'd2) || (op == 3'd3) || (op == 3'd7);
    endfunction

    function automatic logic [31:0] m_enc(input logic [2:0] op, input logic imm_sel,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [15:0] imm);
        int funct;
        funct = (op == 3'd0) ? 32 : (op == 3'd4) ? 36 : (op == 3'd2) ? 37 : (op == 3'd3) ? 34 : 42;
        if (imm_sel)
            return (32'd8 << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
        return (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + 32'(funct);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.in_valid = 0; bus.in_last = 0; bus.op = 0; bus.imm_sel = 0;
        bus.rs = 0; bus.rt = 0; bus.rd = 0; bus.imm = 0;
    endtask

    task automatic fields(input logic [2:0] op, input logic imm_sel, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                          input logic last);
        bus.in_valid = 1; bus.op = op; bus.imm_sel = imm_sel; bus.rs = rs; bus.rt = rt;
        bus.rd = rd; bus.imm = imm; bus.in_last = last;
    endtask

    task automatic begin_session();
        idle_inputs();
        rst = 1; cyc();
        rst = 0; bus.start = 1; cyc();
        bus.start = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; cyc(); cyc();
        checks++; if ({bus.in_ready, bus.mem_we, bus.err, bus.busy, bus.done, bus.full} !== 6'b0) begin errors++; $display("FAIL reset_flags got=%b exp=000000", {bus.in_ready, bus.mem_we, bus.err, bus.busy, bus.done, bus.full}); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 34'd0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata}); end
        rst = 0; bus.in_valid = 1; cyc(); cyc();
        checks++; if ({bus.in_ready, bus.mem_we, bus.busy} !== 3'b0) begin errors++; $display("FAIL idle_ignores_valid got=%b exp=000", {bus.in_ready, bus.mem_we, bus.busy}); end
        bus.in_valid = 0;
    endtask

    task automatic test_single();
        begin_session();
        checks++; if ({bus.busy, bus.in_ready} !== 2'b11) begin errors++; $display("FAIL load_entry got=%b exp=11", {bus.busy, bus.in_ready}); end
        fields(3'd0, 0, 5'd1, 5'd2, 5'd3, 16'h0, 0); cyc(); bus.in_valid = 0;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL single_we got=%b exp=1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 2'd0) begin errors++; $display("FAIL single_addr got=%0d exp=0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h00221820) begin errors++; $display("FAIL single_data got=%h exp=00221820", bus.mem_wdata); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", bus.count); end
        cyc();
        checks++; if ({bus.mem_we, bus.busy} !== 2'b01) begin errors++; $display("FAIL single_pulse got=%b exp=01", {bus.mem_we, bus.busy}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3] = '{32'h20050010, 32'h00222022, 32'h0022302A};
        begin_session();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: fields(3'd0, 1, 5'd0, 5'd5, 5'd0, 16'h0010, 0);
                1: fields(3'd3, 0, 5'd1, 5'd2, 5'd4, 16'h0, 0);
                default: fields(3'd7, 0, 5'd1, 5'd2, 5'd6, 16'h0, 1);
            endcase
            cyc();
            checks++; if ({bus.mem_we, bus.mem_addr} !== {1'b1, 2'(i)}) begin errors++; $display("FAIL b2b_addr%0d got=%b exp=1_%0d", i, {bus.mem_we, bus.mem_addr}, i); end
            checks++; if (bus.mem_wdata !== exp_d[i]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, bus.mem_wdata, exp_d[i]); end
        end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_last got=%b exp=0", bus.in_ready); end
        bus.in_valid = 0; cyc();
        checks++; if ({bus.done, bus.busy, bus.mem_we, bus.count} !== {3'b100, 3'd3}) begin errors++; $display("FAIL b2b_done got=%b exp=100011", {bus.done, bus.busy, bus.mem_we, bus.count}); end
    endtask

    task automatic test_illegal();
        begin_session();
        fields(3'd1, 0, 5'd1, 5'd2, 5'd3, 16'h0, 0); cyc();
        checks++; if ({bus.err, bus.mem_we, bus.count} !== {2'b10, 3'd0}) begin errors++; $display("FAIL illegal_rtype got=%b exp=10000", {bus.err, bus.mem_we, bus.count}); end
        fields(3'd4, 1, 5'd1, 5'd2, 5'd3, 16'h1234, 0); cyc();
        checks++; if ({bus.err, bus.mem_we, bus.count} !== {2'b10, 3'd0}) begin errors++; $display("FAIL illegal_itype got=%b exp=10000", {bus.err, bus.mem_we, bus.count}); end
        fields(3'd4, 0, 5'd1, 5'd2, 5'd3, 16'h0, 0); cyc(); bus.in_valid = 0;
        checks++; if ({bus.err, bus.mem_we, bus.mem_addr} !== {2'b01, 2'd0}) begin errors++; $display("FAIL illegal_then_and got=%b exp=0100", {bus.err, bus.mem_we, bus.mem_addr}); end
        checks++; if (bus.mem_wdata !== 32'h00221824) begin errors++; $display("FAIL and_data got=%h exp=00221824", bus.mem_wdata); end
    endtask

    task automatic test_fill();
        begin_session();
        for (int i = 0; i < 7; i++) begin
            fields(3'd2, 0, 5'(i), 5'd9, 5'(i + 1), 16'h0, 0);
            cyc();
            if (i < 4) begin
                checks++; if ({bus.mem_we, bus.mem_addr} !== {1'b1, 2'(i)}) begin errors++; $display("FAIL fill_write%0d got=%b exp=1_%0d", i, {bus.mem_we, bus.mem_addr}, i); end
            end else begin
                checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL fill_extra%0d got=%b exp=0", i, bus.mem_we); end
            end
            if (i == 3) begin
                checks++; if ({bus.full, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL fill_full got=%b exp=10", {bus.full, bus.in_ready}); end
            end
        end
        bus.in_valid = 0;
        checks++; if ({bus.done, bus.full, bus.count} !== {2'b11, 3'd4}) begin errors++; $display("FAIL fill_done got=%b exp=11100", {bus.done, bus.full, bus.count}); end
    endtask

    task automatic test_restart();
        int wr = 0;
        // Still in DONE from the fill; restart and feed with gaps.
        bus.start = 1; cyc(); bus.start = 0;
        checks++; if ({bus.busy, bus.done, bus.full, bus.count} !== {3'b100, 3'd0}) begin errors++; $display("FAIL restart_clear got=%b exp=100000", {bus.busy, bus.done, bus.full, bus.count}); end
        for (int i = 0; i < 6; i++) begin
            if (i % 3 == 0) fields(3'd0, 1, 5'd3, 5'(i), 5'd0, 16'(i * 7), 0);
            else bus.in_valid = 0;
            cyc();
            if (i % 3 == 0) begin
                checks++; if ({bus.mem_we, bus.mem_addr, bus.count} !== {1'b1, 2'(wr), 3'(wr + 1)}) begin errors++; $display("FAIL restart_wr%0d got=%b exp=1_%0d_%0d", wr, {bus.mem_we, bus.mem_addr, bus.count}, wr, wr + 1); end
                wr++;
            end else begin
                checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL restart_gap%0d got=%b exp=0", i, bus.mem_we); end
            end
        end
        bus.in_valid = 0;
    endtask

    task automatic test_reset_mid();
        begin_session();
        fields(3'd0, 0, 5'd1, 5'd1, 5'd1, 16'h0, 0); cyc();
        fields(3'd3, 0, 5'd2, 5'd2, 5'd2, 16'h0, 0); cyc();
        checks++; if ({bus.mem_we, bus.mem_addr} !== 3'b101) begin errors++; $display("FAIL mid_second_write got=%b exp=101", {bus.mem_we, bus.mem_addr}); end
        rst = 1; cyc(); rst = 0;
        checks++; if ({bus.in_ready, bus.mem_we, bus.err, bus.busy, bus.done, bus.full, bus.count} !== 9'd0) begin errors++; $display("FAIL mid_reset got=%b exp=0", {bus.in_ready, bus.mem_we, bus.err, bus.busy, bus.done, bus.full, bus.count}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 34'd0) begin errors++; $display("FAIL mid_reset_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata}); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if ({bus.mem_we, bus.in_ready, bus.busy} !== 3'b0) begin errors++; $display("FAIL mid_idle%0d got=%b exp=000", i, {bus.mem_we, bus.in_ready, bus.busy}); end
        end
        bus.in_valid = 0;
    endtask

    task automatic test_random(input int sessions);
        for (int s = 0; s < sessions; s++) begin
            logic [2:0]  r_op  [6];
            logic        r_sel [6];
            logic [4:0]  r_rs [6], r_rt [6], r_rd [6];
            logic [15:0] r_imm [6];
            int n_items, last_idx, idx, m_cnt;
            bit m_pend, m_done, present, exp_ready, xfer, was_pend, exp_we, exp_err;
            logic [1:0]  exp_addr;
            logic [31:0] exp_data;
            n_items = $urandom_range(1, 6);
            last_idx = $urandom_range(0, 7);
            for (int k = 0; k < 6; k++) begin
                r_sel[k] = ($urandom % 3 == 0);
                r_op[k]  = (r_sel[k] && ($urandom % 4 != 0)) ? 3'd0 : 3'($urandom_range(0, 7));
                r_rs[k] = 5'($urandom); r_rt[k] = 5'($urandom); r_rd[k] = 5'($urandom);
                r_imm[k] = 16'($urandom);
            end
            idx = 0; m_cnt = 0; m_pend = 0; m_done = 0; exp_addr = 0; exp_data = 0;
            begin_session();
            for (int c = 0; c < 24; c++) begin
                present = (idx < n_items) && ($urandom % 4 != 0);
                bus.start = !m_done && ($urandom % 10 == 0);
                if (idx < n_items) fields(r_op[idx], r_sel[idx], r_rs[idx], r_rt[idx], r_rd[idx], r_imm[idx], idx == last_idx);
                bus.in_valid = present;
                exp_ready = !m_done && !m_pend && (m_cnt < DEPTH);
                checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready s%0d c%0d got=%b exp=%b", s, c, bus.in_ready, exp_ready); end
                xfer = present && exp_ready;
                cyc();
                exp_we = 0; exp_err = 0; was_pend = m_pend;
                if (xfer) begin
                    if (m_legal(r_op[idx], r_sel[idx])) begin
                        exp_we = 1; exp_addr = 2'(m_cnt);
                        exp_data = m_enc(r_op[idx], r_sel[idx], r_rs[idx], r_rt[idx], r_rd[idx], r_imm[idx]);
                        m_cnt++;
                    end else begin
                        exp_err = 1;
                    end
                    if (idx == last_idx || m_cnt == DEPTH) m_pend = 1;
                    idx++;
                end
                if (was_pend) begin m_done = 1; m_pend = 0; end
                checks++; if ({bus.mem_we, bus.err, bus.done, bus.busy} !== {exp_we, exp_err, m_done, !m_done}) begin errors++; $display("FAIL rnd_ctrl s%0d c%0d got=%b exp=%b", s, c, {bus.mem_we, bus.err, bus.done, bus.busy}, {exp_we, exp_err, m_done, !m_done}); end
                checks++; if (bus.count !== 3'(m_cnt)) begin errors++; $display("FAIL rnd_count s%0d c%0d got=%0d exp=%0d", s, c, bus.count, m_cnt); end
                if (exp_we) begin
                    checks++; if ({bus.mem_addr, bus.mem_wdata} !== {exp_addr, exp_data}) begin errors++; $display("FAIL rnd_write s%0d c%0d got=%h_%h exp=%h_%h", s, c, bus.mem_addr, bus.mem_wdata, exp_addr, exp_data); end
                end
            end
            idle_inputs();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_fill();
        test_restart();
        test_reset_mid();
        test_random(40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
